// File: rtl/d8m_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d8m_emu_pkg
// Description : Shared definitions for the D8M camera-side sensor emulator:
//               pattern mode encodings, frame-timing FSM states and the
//               8-entry colour-bar table (RGB bits, white first).
// Revision    : 1.0 - initial release
// ============================================================================
package d8m_emu_pkg;

  // Pattern select encodings
  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_SOLID = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  // Frame timing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRONT  = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } state_t;

  // Colour bars, left to right, as {R,G,B}:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage
`default_nettype wire

// File: rtl/d8m_emu_pattern.sv
`default_nettype none
// ============================================================================
// Module      : d8m_emu_pattern
// Description : Combinational pattern generator. Maps the latched mode and
//               the active-area coordinates of a pixel to its 12-bit raw
//               Bayer (GRBG) value.
// Ports       : i_mode        pattern select (ramp/bars/solid/checker)
//               i_x, i_y      active pixel coordinates
//               i_bar         colour bar index 0..7
//               i_row_odd     y parity
//               i_col_odd     x parity
//               i_solid_value value for the solid pattern
//               o_pixel       resulting pixel value
// Revision    : 1.0 - initial release
// ============================================================================
module d8m_emu_pattern
  import d8m_emu_pkg::*;
(
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [2:0]  i_bar,
  input  logic        i_row_odd,
  input  logic        i_col_odd,
  input  logic [11:0] i_solid_value,
  output logic [11:0] o_pixel
);

  logic [2:0] w_rgb;
  logic       w_bayer_bit;

  always_comb begin
    w_rgb = BAR_RGB[i_bar];
    // GRBG: even row G,R ; odd row B,G
    case ({i_row_odd, i_col_odd})
      2'b00:   w_bayer_bit = w_rgb[1];
      2'b01:   w_bayer_bit = w_rgb[2];
      2'b10:   w_bayer_bit = w_rgb[0];
      default: w_bayer_bit = w_rgb[1];
    endcase

    case (i_mode)
      MODE_RAMP:  o_pixel = i_x + i_y;
      MODE_BARS:  o_pixel = {12{w_bayer_bit}};
      MODE_SOLID: o_pixel = i_solid_value;
      default:    o_pixel = (i_x[4] ^ i_y[4]) ? 12'hFFF : 12'h000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/d8m_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : d8m_sensor_emulator
// Description : Synthetic raw-Bayer image source driving the D8M camera-side
//               parallel interface (D, FVAL, LVAL, PIXCLK) with programmable
//               frame timing and test patterns.
// Ports       : clk, reset           system clock, sync active-high reset
//               i_enable             run frames while high
//               i_mode               0 ramp, 1 bars, 2 solid, 3 checker
//               i_solid_value        solid pattern value
//               o_cam_d/fval/lval    camera data and sync
//               o_cam_pixclk         generated pixel clock
//               o_frame_done         1-clk pulse at FVAL fall
//               o_frame_count        completed frames (wraps)
//               o_busy               FVAL rise through end of vertical blank
//               o_checksum           (D8M_EMU_CHECKSUM_EN only) sum of the
//                                    last completed frame's active pixels
// Options     : define D8M_EMU_CHECKSUM_EN to add o_checksum
// Revision    : 1.0 - initial release
// ============================================================================
module d8m_sensor_emulator
  import d8m_emu_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 32,
  parameter int V_FRONT  = 16,
  parameter int V_BLANK  = 1000,
  parameter int PCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_solid_value,
  output logic [11:0] o_cam_d,
  output logic        o_cam_fval,
  output logic        o_cam_lval,
  output logic        o_cam_pixclk,
  output logic        o_frame_done,
  output logic [15:0] o_frame_count,
  output logic        o_busy
`ifdef D8M_EMU_CHECKSUM_EN
  ,
  output logic [15:0] o_checksum
`endif
);

  localparam int c_div_w  = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
  localparam int c_bar_px = H_ACTIVE / 8;
  localparam int c_bpix_w = (c_bar_px > 1) ? $clog2(c_bar_px) : 1;

  // Pixel-period divider. The strobe marks the edge on which the divider
  // returns to 0, so data, sync and the falling pixclk edge move together
  // and the pixclk rising edge lands mid-pixel.
  logic [c_div_w-1:0] r_div;
  logic [c_div_w-1:0] w_div_n;
  logic               w_stb;
  logic               w_pixclk_n;

  assign w_stb      = (r_div == c_div_w'(PCLK_DIV - 1));
  assign w_div_n    = w_stb ? '0 : r_div + 1'b1;
  assign w_pixclk_n = (w_div_n >= c_div_w'(PCLK_DIV / 2));

  state_t             r_state, w_state_n;
  logic [15:0]        r_cnt, w_cnt_n;
  logic [11:0]        r_x, w_x_n;
  logic [11:0]        r_y, w_y_n;
  logic [2:0]         r_bar, w_bar_n;
  logic [c_bpix_w-1:0] r_bpix, w_bpix_n;
  logic               r_fval, w_fval_n;
  logic               r_lval, w_lval_n;
  logic               w_start;
  logic               w_done;

  logic [1:0]         r_mode;
  logic [11:0]        r_solid;
  logic [11:0]        r_d;
  logic               r_pixclk;
  logic               r_done;
  logic [15:0]        r_count;
  logic               r_busy;
  logic [11:0]        w_pixel;

  // Next-state for the coming pixel period; only applied on a strobe.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_bar_n   = r_bar;
    w_bpix_n  = r_bpix;
    w_fval_n  = r_fval;
    w_lval_n  = r_lval;
    w_start   = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_enable) w_start = 1'b1;
      end
      FRONT: begin
        if (r_cnt == 16'(V_FRONT - 1)) begin
          w_state_n = ACTIVE;
          w_lval_n  = 1'b1;
          w_x_n     = '0;
          w_bar_n   = '0;
          w_bpix_n  = '0;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      ACTIVE: begin
        if (r_x == 12'(H_ACTIVE - 1)) begin
          w_lval_n = 1'b0;
          w_cnt_n  = '0;
          if (r_y == 12'(V_ACTIVE - 1)) begin
            w_state_n = VBLANK;
            w_fval_n  = 1'b0;
            w_done    = 1'b1;
          end else begin
            w_state_n = HBLANK;
          end
        end else begin
          w_x_n = r_x + 12'd1;
          if (r_bpix == c_bpix_w'(c_bar_px - 1)) begin
            w_bpix_n = '0;
            w_bar_n  = r_bar + 3'd1;
          end else begin
            w_bpix_n = r_bpix + 1'b1;
          end
        end
      end
      HBLANK: begin
        if (r_cnt == 16'(H_BLANK - 1)) begin
          w_state_n = ACTIVE;
          w_lval_n  = 1'b1;
          w_x_n     = '0;
          w_y_n     = r_y + 12'd1;
          w_bar_n   = '0;
          w_bpix_n  = '0;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      VBLANK: begin
        // Back-to-back frames start right as the blank ends, so a frame
        // period is exactly FVAL-high time plus V_BLANK.
        if (r_cnt == 16'(V_BLANK - 1)) begin
          if (i_enable) w_start = 1'b1;
          else          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase

    if (w_start) begin
      w_state_n = FRONT;
      w_cnt_n   = '0;
      w_fval_n  = 1'b1;
      w_lval_n  = 1'b0;
      w_y_n     = '0;
    end
  end

  d8m_emu_pattern u_pattern (
    .i_mode        (r_mode),
    .i_x           (w_x_n),
    .i_y           (w_y_n),
    .i_bar         (w_bar_n),
    .i_row_odd     (w_y_n[0]),
    .i_col_odd     (w_x_n[0]),
    .i_solid_value (r_solid),
    .o_pixel       (w_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div    <= '0;
      r_pixclk <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_bar    <= '0;
      r_bpix   <= '0;
      r_fval   <= 1'b0;
      r_lval   <= 1'b0;
      r_d      <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_mode   <= MODE_RAMP;
      r_solid  <= '0;
    end else begin
      r_div    <= w_div_n;
      r_pixclk <= w_pixclk_n;
      r_done   <= 1'b0;
      if (w_stb) begin
        r_state <= w_state_n;
        r_cnt   <= w_cnt_n;
        r_x     <= w_x_n;
        r_y     <= w_y_n;
        r_bar   <= w_bar_n;
        r_bpix  <= w_bpix_n;
        r_fval  <= w_fval_n;
        r_lval  <= w_lval_n;
        r_d     <= w_lval_n ? w_pixel : 12'h000;
        r_done  <= w_done;
        r_busy  <= (w_state_n != IDLE);
        if (w_done)  r_count <= r_count + 16'd1;
        if (w_start) begin
          r_mode  <= i_mode;
          r_solid <= i_solid_value;
        end
      end
    end
  end

  assign o_cam_d       = r_d;
  assign o_cam_fval    = r_fval;
  assign o_cam_lval    = r_lval;
  assign o_cam_pixclk  = r_pixclk;
  assign o_frame_done  = r_done;
  assign o_frame_count = r_count;
  assign o_busy        = r_busy;

`ifdef D8M_EMU_CHECKSUM_EN
  logic [15:0] r_acc;
  logic [15:0] r_checksum;

  // Accumulates the value being registered into cam_d, so the last pixel
  // is already included by the time the frame_done strobe arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else if (w_stb) begin
      if (w_start)       r_acc <= '0;
      else if (w_lval_n) r_acc <= r_acc + {4'h0, w_pixel};
      if (w_done)        r_checksum <= r_acc;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d8m_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_d8m_sensor_emulator
// Description : Scoreboard bench for d8m_sensor_emulator. Stimulus pushes the
//               expected pixel stream per frame; monitors pop and compare on
//               every active pixel and check frame timing. A second instance
//               with PCLK_DIV=4 checks pixclk shape and data alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d8m_sensor_emulator;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int HB = 4;
  localparam int VF = 3;
  localparam int VB = 5;

  localparam logic [1:0] M_RAMP  = 2'd0;
  localparam logic [1:0] M_BARS  = 2'd1;
  localparam logic [1:0] M_SOLID = 2'd2;
  localparam logic [1:0] M_CHECK = 2'd3;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] solid;

  logic [11:0] o_d, o_d2;
  logic        o_fval, o_lval, o_pclk, o_done, o_busy;
  logic        o_fval2, o_lval2, o_pclk2, o_done2, o_busy2;
  logic [15:0] o_count, o_count2;
`ifdef D8M_EMU_CHECKSUM_EN
  logic [15:0] o_sum, o_sum2;
`endif

  d8m_sensor_emulator #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_FRONT(VF),
                        .V_BLANK(VB), .PCLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .i_enable(en), .i_mode(mode), .i_solid_value(solid),
    .o_cam_d(o_d), .o_cam_fval(o_fval), .o_cam_lval(o_lval), .o_cam_pixclk(o_pclk),
    .o_frame_done(o_done), .o_frame_count(o_count), .o_busy(o_busy)
`ifdef D8M_EMU_CHECKSUM_EN
    , .o_checksum(o_sum)
`endif
  );

  d8m_sensor_emulator #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_FRONT(VF),
                        .V_BLANK(VB), .PCLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .i_enable(1'b1), .i_mode(M_RAMP), .i_solid_value(12'h000),
    .o_cam_d(o_d2), .o_cam_fval(o_fval2), .o_cam_lval(o_lval2), .o_cam_pixclk(o_pclk2),
    .o_frame_done(o_done2), .o_frame_count(o_count2), .o_busy(o_busy2)
`ifdef D8M_EMU_CHECKSUM_EN
    , .o_checksum(o_sum2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int x; int y; logic [11:0] v; } pix_t;
  pix_t        q_pix[$];
  logic [15:0] q_sum[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference pixel value from the pattern definitions
  function automatic logic [11:0] model_pix(input logic [1:0] m, input int x, input int y,
                                            input logic [11:0] sv);
    int bar;
    logic r, g, b, bit_v;
    bar = x / (H / 8);
    case (bar)
      0: {r, g, b} = 3'b111;  // white
      1: {r, g, b} = 3'b110;  // yellow
      2: {r, g, b} = 3'b011;  // cyan
      3: {r, g, b} = 3'b010;  // green
      4: {r, g, b} = 3'b101;  // magenta
      5: {r, g, b} = 3'b100;  // red
      6: {r, g, b} = 3'b001;  // blue
      default: {r, g, b} = 3'b000;
    endcase
    if (y % 2 == 0) bit_v = (x % 2 == 0) ? g : r;
    else            bit_v = (x % 2 == 0) ? b : g;
    case (m)
      M_RAMP:  return 12'((x + y) % 4096);
      M_BARS:  return bit_v ? 12'hFFF : 12'h000;
      M_SOLID: return sv;
      default: return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic [11:0] sv);
    pix_t p;
    logic [15:0] s;
    s = 16'h0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        p.x = x; p.y = y; p.v = model_pix(m, x, y, sv);
        s = s + {4'h0, p.v};
        q_pix.push_back(p);
      end
    end
    q_sum.push_back(s);
  endtask

  task automatic wait_frame_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_done) return;
    end
    check("timeout_frame_done", 32'd0, 32'd1);
  endtask

  task automatic wait_lval_rise();
    logic prev;
    prev = o_lval;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_lval && !prev) return;
      prev = o_lval;
    end
    check("timeout_lval_rise", 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------- monitor
  pix_t m_p;
  logic m_pfv = 1'b0, m_plv = 1'b0, m_pdone = 1'b0;
  int   m_fvrun = 0, m_lvrun = 0, m_lvpulses = 0, m_expcount = 0;
  int   m_ndone = 0, m_lastdone = 0;
  logic [15:0] m_sum;

  always @(negedge clk) begin
    if (reset) begin
      m_pfv = 1'b0; m_plv = 1'b0; m_pdone = 1'b0;
      m_fvrun = 0; m_lvrun = 0; m_lvpulses = 0; m_expcount = 0;
    end else begin
      if (o_pclk) begin
        if (o_lval) begin
          if (q_pix.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL pix_unexpected: got 0x%0h expected none", o_d);
          end else begin
            m_p = q_pix.pop_front();
            check($sformatf("pix_x%0d_y%0d", m_p.x, m_p.y), {20'h0, o_d}, {20'h0, m_p.v});
          end
        end else begin
          check("d_zero_blank", {20'h0, o_d}, 32'h0);
        end
      end
      if (o_fval) m_fvrun++;
      if (o_lval && !m_plv) m_lvpulses++;
      if (o_lval) m_lvrun++;
      if (m_plv && !o_lval) begin
        check("lval_width_clk", m_lvrun, 2 * H);
        m_lvrun = 0;
      end
      if (m_pfv && !o_fval) begin
        check("fval_width_clk", m_fvrun, 158);
        check("lval_pulses", m_lvpulses, V);
        m_fvrun = 0; m_lvpulses = 0;
      end
      if (o_done || (m_pfv && !o_fval)) begin
        check("done_at_fval_fall", {31'h0, o_done}, {31'h0, m_pfv && !o_fval});
      end
      if (o_done) begin
        if (m_pdone) check("done_width", 32'd2, 32'd1);
        m_expcount++;
        m_ndone++;
        check("frame_count", {16'h0, o_count}, 32'(m_expcount));
        if (m_ndone == 2 || m_ndone == 3) check("done_interval", cyc - m_lastdone, 168);
        m_lastdone = cyc;
        if (q_sum.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got pulse expected none");
        end else begin
          m_sum = q_sum.pop_front();
`ifdef D8M_EMU_CHECKSUM_EN
          check("checksum", {16'h0, o_sum}, {16'h0, m_sum});
`endif
        end
      end
      m_pfv = o_fval; m_plv = o_lval; m_pdone = o_done;
    end
  end

  // ----------------------------------------------- PCLK_DIV=4 monitor
  logic       m2_started = 1'b0, m2_runvalid = 1'b0;
  logic       m2_ppclk = 1'b0, m2_pfv = 1'b0, m2_plv = 1'b0;
  logic [11:0] m2_pd = 12'h0;
  int         m2_run = 0, m2_x = 0, m2_y = 0;

  always @(negedge clk) begin
    if (reset) begin
      m2_started = 1'b0; m2_runvalid = 1'b0; m2_pfv = 1'b0; m2_plv = 1'b0;
    end else if (!m2_started) begin
      m2_started = 1'b1; m2_run = 1;
      m2_ppclk = o_pclk2; m2_pd = o_d2;
    end else begin
      if (o_d2 != m2_pd) check("d4_change_on_pclk_fall", {30'h0, m2_ppclk, o_pclk2}, 32'h2);
      if (o_pclk2 != m2_ppclk) begin
        if (m2_runvalid) check(m2_ppclk ? "pclk4_high_clk" : "pclk4_low_clk", m2_run, 2);
        m2_runvalid = 1'b1;
        m2_run = 1;
      end else begin
        m2_run++;
      end
      // First high clock of each pixel period
      if (o_pclk2 && !m2_ppclk) begin
        if (o_fval2 && !m2_pfv) m2_y = 0;
        if (o_lval2) begin
          if (!m2_plv) m2_x = 0;
          check("pix4_ramp", {20'h0, o_d2}, 32'((m2_x + m2_y) % 4096));
          m2_x++;
        end else if (m2_plv) begin
          m2_y++;
        end
        m2_pfv = o_fval2; m2_plv = o_lval2;
      end
      m2_ppclk = o_pclk2; m2_pd = o_d2;
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int fv_seen;
    reset = 1'b1; en = 1'b0; mode = M_RAMP; solid = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_d",     {20'h0, o_d},     32'h0);
    check("rst_fval",  {31'h0, o_fval},  32'h0);
    check("rst_lval",  {31'h0, o_lval},  32'h0);
    check("rst_pclk",  {31'h0, o_pclk},  32'h0);
    check("rst_done",  {31'h0, o_done},  32'h0);
    check("rst_count", {16'h0, o_count}, 32'h0);
    check("rst_busy",  {31'h0, o_busy},  32'h0);

    // Frame 1 ramp; frame 2 bars selected mid-frame 1
    push_frame(M_RAMP, 12'h000);
    en = 1'b1; reset = 1'b0;
    wait_lval_rise();
    mode = M_BARS;
    push_frame(M_BARS, 12'h000);
    wait_frame_done();

    // Solid selected mid-frame 2; frame 2 must stay bars
    wait_lval_rise();
    mode = M_SOLID; solid = 12'hA5A;
    push_frame(M_SOLID, 12'hA5A);
    wait_frame_done();

    // Drop enable during line 1 of frame 3
    wait_lval_rise();
    wait_lval_rise();
    en = 1'b0;
    wait_frame_done();
    for (int i = 1; i <= 2 * VB; i++) begin
      @(negedge clk);
      if (i == 2 * VB - 1) check("busy_in_vblank", {31'h0, o_busy}, 32'h1);
      if (i == 2 * VB)     check("busy_after_vblank", {31'h0, o_busy}, 32'h0);
    end
    check("count_after_stop", {16'h0, o_count}, 32'h3);
    fv_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_fval) fv_seen++;
    end
    check("no_fval_when_disabled", fv_seen, 0);

    // Reset mid-line
    mode = M_RAMP;
    push_frame(M_RAMP, 12'h000);
    en = 1'b1;
    wait_lval_rise();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q_pix.delete();
    q_sum.delete();
    @(negedge clk);
    check("mid_rst_d",     {20'h0, o_d},     32'h0);
    check("mid_rst_fval",  {31'h0, o_fval},  32'h0);
    check("mid_rst_lval",  {31'h0, o_lval},  32'h0);
    check("mid_rst_pclk",  {31'h0, o_pclk},  32'h0);
    check("mid_rst_done",  {31'h0, o_done},  32'h0);
    check("mid_rst_busy",  {31'h0, o_busy},  32'h0);
    check("mid_rst_count", {16'h0, o_count}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_done", {31'h0, o_done}, 32'h0);
    end
    mode = M_CHECK;
    push_frame(M_CHECK, 12'h000);
    reset = 1'b0;
    @(negedge clk);
    check("fval_before_strobe", {31'h0, o_fval}, 32'h0);
    @(negedge clk);
    check("fval_first_strobe", {31'h0, o_fval}, 32'h1);
    check("busy_first_strobe", {31'h0, o_busy}, 32'h1);
    wait_frame_done();
    en = 1'b0;
    repeat (40) @(negedge clk);

    check("pix_queue_drained", q_pix.size(), 0);
    check("sum_queue_drained", q_sum.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
